// File: rtl/vgacon_text_ctrl.sv
// Command sequencer for the VGA console text buffer: owns the buffer write port and
// runs cursor advance, hardware clear and hardware scroll-up (row copy + blank fill).
module vgacon_text_ctrl #(
  parameter int         COLS  = 12,
  parameter int         ROWS  = 4,
  parameter int         AW    = 6,
  parameter logic [6:0] BLANK = 7'h20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd_op,
  input  logic [6:0]    cmd_data,
  output logic          cmd_ready,
  output logic          buf_we,
  output logic [AW-1:0] buf_waddr,
  output logic [6:0]    buf_wdata,
  output logic [AW-1:0] buf_raddr,
  input  logic [6:0]    buf_rdata,
  output logic [AW-1:0] cursor,
  output logic          busy,
  output logic          done
);

  localparam int CELLS = COLS * ROWS;
  localparam logic [AW-1:0] LAST   = AW'(CELLS - 1);
  localparam logic [AW-1:0] SPAN   = AW'(CELLS - COLS);
  localparam logic [AW-1:0] C_COLS = AW'(COLS);
  localparam logic [AW:0]   C_CELLS = (AW+1)'(CELLS);

  localparam logic [1:0] OP_PUTC    = 2'b00;
  localparam logic [1:0] OP_SETCUR  = 2'b01;
  localparam logic [1:0] OP_CLEAR   = 2'b10;
  localparam logic [1:0] OP_NEWLINE = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_COPY, S_FILL, S_CLEAR} state_t;

  state_t        r_state;
  logic [AW-1:0] r_cursor;
  logic [AW-1:0] r_cnt;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [6:0]    r_wdata;
  logic [AW-1:0] r_raddr;
  logic          r_done;

  logic          w_idle;
  logic          w_putc;
  logic          w_newline;
  logic          w_setcur;
  logic          w_clear;
  logic          w_last_row;
  logic          w_setcur_ok;
  logic [AW-1:0] w_row;
  logic [AW-1:0] w_next_row;

  assign w_idle      = (r_state == S_IDLE);
  assign w_putc      = cmd_valid && (cmd_op == OP_PUTC) && (cmd_data != 7'h0A);
  assign w_newline   = cmd_valid && ((cmd_op == OP_NEWLINE) ||
                                     ((cmd_op == OP_PUTC) && (cmd_data == 7'h0A)));
  assign w_setcur    = cmd_valid && (cmd_op == OP_SETCUR);
  assign w_clear     = cmd_valid && (cmd_op == OP_CLEAR);
  assign w_row       = r_cursor / C_COLS;
  assign w_next_row  = (w_row + AW'(1)) * C_COLS;
  assign w_last_row  = (r_cursor >= SPAN);
  assign w_setcur_ok = ({1'b0, cmd_data[AW-1:0]} < C_CELLS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cursor <= '0;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_raddr  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_we <= 1'b0;
          if (w_putc) begin
            r_we    <= 1'b1;
            r_waddr <= r_cursor;
            r_wdata <= cmd_data;
            if (r_cursor == LAST) begin
              r_state  <= S_COPY;
              r_cursor <= SPAN;
              r_raddr  <= C_COLS;
              r_cnt    <= '0;
            end else begin
              r_cursor <= r_cursor + AW'(1);
            end
          end else if (w_newline) begin
            if (w_last_row) begin
              r_state  <= S_COPY;
              r_cursor <= SPAN;
              r_raddr  <= C_COLS;
              r_cnt    <= '0;
            end else begin
              r_cursor <= w_next_row;
            end
          end else if (w_setcur) begin
            r_cursor <= w_setcur_ok ? cmd_data[AW-1:0] : '0;
          end else if (w_clear) begin
            r_state  <= S_CLEAR;
            r_cursor <= '0;
            r_we     <= 1'b1;
            r_waddr  <= '0;
            r_wdata  <= BLANK;
          end
        end
        // r_cnt = k: read cell k+COLS issued last cycle lands in cell k next cycle
        S_COPY: begin
          r_we <= 1'b1;
          if (r_cnt == SPAN) begin
            r_state <= S_FILL;
            r_waddr <= SPAN;
            r_wdata <= BLANK;
          end else begin
            r_waddr <= r_cnt;
            r_cnt   <= r_cnt + AW'(1);
            if (r_cnt != SPAN - AW'(1))
              r_raddr <= r_cnt + C_COLS + AW'(1);
          end
        end
        S_FILL, S_CLEAR: begin
          if (r_waddr == LAST) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_waddr <= r_waddr + AW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Copy writes take the RAM read data of the same cycle; everything else is registered.
  assign buf_wdata = ((r_state == S_COPY) && (r_cnt != '0)) ? buf_rdata : r_wdata;
  assign buf_we    = r_we;
  assign buf_waddr = r_waddr;
  assign buf_raddr = r_raddr;
  assign cursor    = r_cursor;
  assign done      = r_done;
  assign cmd_ready = w_idle;
  assign busy      = !w_idle;

endmodule

// File: tb/tb_vgacon_text_ctrl.sv
// Scoreboard bench for vgacon_text_ctrl with a registered-read text RAM model.
module tb_vgacon_text_ctrl;

  localparam int CELLS = 48;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [6:0] cmd_data = 7'h00;
  logic       cmd_ready, buf_we, busy, done;
  logic [5:0] buf_waddr, buf_raddr, cursor;
  logic [6:0] buf_wdata, buf_rdata;

  logic [6:0]  mem [0:63];
  logic [6:0]  model [0:47];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_addr = '0;
  logic [6:0]  bd_data = '0;
  logic [12:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          ready_low = 0;
  int          done_cnt = 0;
  int          cur_m = 0;

  vgacon_text_ctrl dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .buf_we(buf_we),
    .buf_waddr(buf_waddr), .buf_wdata(buf_wdata), .buf_raddr(buf_raddr),
    .buf_rdata(buf_rdata), .cursor(cursor), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    buf_rdata <= mem[buf_raddr];
    if (buf_we) mem[buf_waddr] <= buf_wdata;
    else if (bd_we) mem[bd_addr] <= bd_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (!cmd_ready) ready_low++;
      if (done) done_cnt++;
      if (buf_we) begin
        if (exp_q.size() == 0) check("wr_extra", {19'd0, buf_waddr, buf_wdata}, 32'hFFFF);
        else check("wr", {19'd0, buf_waddr, buf_wdata}, {19'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic push_wr(input int a, input logic [6:0] d);
    exp_q.push_back({a[5:0], d});
    model[a] = d;
  endtask

  task automatic push_scroll();
    for (int k = 0; k < 36; k++) push_wr(k, model[k + 12]);
    for (int k = 36; k < 48; k++) push_wr(k, 7'h20);
    cur_m = 36;
  endtask

  task automatic send(input logic [1:0] op, input logic [6:0] d);
    int n;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) check("ready_timeout", 0, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_newline();
    if (cur_m / 12 == 3) push_scroll();
    else cur_m = (cur_m / 12 + 1) * 12;
    send(2'b11, 7'h00);
  endtask

  task automatic put(input logic [6:0] c);
    if (c == 7'h0A) begin
      if (cur_m / 12 == 3) push_scroll();
      else cur_m = (cur_m / 12 + 1) * 12;
    end else begin
      push_wr(cur_m, c);
      if (cur_m == 47) push_scroll();
      else cur_m++;
    end
    send(2'b00, c);
  endtask

  task automatic setcur(input logic [6:0] d);
    cur_m = (d[5:0] < 6'd48) ? int'(d[5:0]) : 0;
    send(2'b01, d);
  endtask

  task automatic do_clear();
    for (int k = 0; k < CELLS; k++) push_wr(k, 7'h20);
    cur_m = 0;
    send(2'b10, 7'h00);
  endtask

  task automatic bd_write(input int a, input logic [6:0] d);
    bd_we = 1'b1; bd_addr = a[5:0]; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
    model[a] = d;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) check("idle_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, cmd_ready}, 1);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_we"}, {31'd0, buf_we}, 0);
    check({tag, "_waddr"}, {26'd0, buf_waddr}, 0);
    check({tag, "_wdata"}, {25'd0, buf_wdata}, 0);
    check({tag, "_raddr"}, {26'd0, buf_raddr}, 0);
    check({tag, "_cursor"}, {26'd0, cursor}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) bd_write(i % 48, 7'h00);
    check_reset_outputs("rst");
    reset = 1'b0;

    // 1: three PUTCs advance the cursor with no done
    for (int i = 0; i < 3; i++) put(7'h41);
    wait_idle();
    check("t1_cursor", {26'd0, cursor}, 3);
    check("t1_done", done_cnt, 0);
    check("t1_sb", exp_q.size(), 0);

    // 2: PUTC at the last cell scrolls
    setcur(7'd46);
    check("t2_setcur", {26'd0, cursor}, 46);
    put(7'h58);
    ready_low = 0; done_cnt = 0;
    put(7'h59);
    wait_idle();
    check("t2_ready_low", ready_low, 49);
    check("t2_done", done_cnt, 1);
    check("t2_cursor", {26'd0, cursor}, 36);
    check("t2_cell35", {25'd0, mem[35]}, 32'h59);
    for (int i = 36; i < 48; i++) check("t2_blank", {25'd0, mem[i]}, 32'h20);
    check("t2_sb", exp_q.size(), 0);

    // 3: NEWLINE on the bottom row scrolls preloaded rows
    for (int i = 0; i < CELLS; i++) bd_write(i, 7'h61 + 7'(i / 12));
    setcur(7'd40);
    done_cnt = 0;
    do_newline();
    wait_idle();
    check("t3_cursor", {26'd0, cursor}, 36);
    check("t3_done", done_cnt, 1);
    for (int i = 0; i < CELLS; i++)
      check("t3_cell", {25'd0, mem[i]}, (i < 36) ? 32'h62 + i / 12 : 32'h20);
    check("t3_sb", exp_q.size(), 0);

    // 4: CLEAR
    setcur(7'd17);
    ready_low = 0; done_cnt = 0;
    do_clear();
    check("t4_cursor", {26'd0, cursor}, 0);
    wait_idle();
    check("t4_ready_low", ready_low, 48);
    check("t4_done", done_cnt, 1);
    check("t4_sb", exp_q.size(), 0);

    // 5: out-of-range SETCUR and mid-screen NEWLINE
    setcur(7'd50);
    check("t5_setcur", {26'd0, cursor}, 0);
    setcur(7'd5);
    do_newline();
    put(7'h0A);
    wait_idle();
    check("t5_cursor", {26'd0, cursor}, 24);
    check("t5_sb", exp_q.size(), 0);

    // 6: reset mid-COPY aborts the scroll
    setcur(7'd47);
    done_cnt = 0;
    put(7'h5A);
    repeat (10) @(posedge clk);
    #1;
    check("t6_busy_pre", {31'd0, busy}, 1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_reset_outputs("t6");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cur_m = 0;
    put(7'h51);
    wait_idle();
    check("t6_cursor", {26'd0, cursor}, 1);
    check("t6_done", done_cnt, 0);
    check("t6_sb", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
